// File: rtl/clock_pkg.sv
// Shared widths, limits, alarm states and request indices for the clock's
// timekeeping and alarm sequencer.
package clock_pkg;

  localparam int SEC_W       = 6;
  localparam int HR_W        = 4;
  localparam int MIN_SEC_MAX = 59;
  localparam int AL_STEP     = 10;

  typedef enum logic [1:0] {
    OFF,
    ARMED,
    RINGING,
    HOLDOFF
  } al_state_e;

  // Lower index wins arbitration
  localparam int REQ_TICK = 0;
  localparam int REQ_SEC  = 1;
  localparam int REQ_MIN  = 2;
  localparam int REQ_HRS  = 3;
  localparam int REQ_AL   = 4;
  localparam int NUM_REQ  = 5;

  function automatic logic [NUM_REQ-1:0] first_set(input logic [NUM_REQ-1:0] req);
    return req & (~req + NUM_REQ'(1));
  endfunction

endpackage

// File: rtl/time_alarm_ctrl_wrap_inc.sv
// Wrapping incrementer: adds STEP to a field and returns to zero after the
// last reachable value at or below MAX, flagging the wrap as a carry.
module wrap_inc #(
  parameter int W    = 6,
  parameter int MAX  = 59,
  parameter int STEP = 1
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] next_o,
  output logic         carry_o
);

  // Fields only ever hold multiples of STEP, so equality with the last one suffices
  localparam logic [W-1:0] LAST = W'((MAX / STEP) * STEP);

  assign carry_o = (val_i == LAST);
  assign next_o  = carry_o ? '0 : val_i + W'(STEP);

endmodule

// File: rtl/time_alarm_ctrl.sv
// Timekeeping/alarm sequencer: one arbitrated register update per cycle
// (tick > sec > min > hrs > al) plus the alarm on/ringing state machine.
module time_alarm_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SECS = 60,
  parameter int HOURS_MOD = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             sec_adj,
  input  logic             min_adj,
  input  logic             hrs_adj,
  input  logic             al_adj,
  input  logic             al_toggle,
  output logic [SEC_W-1:0] seconds,
  output logic [SEC_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [SEC_W-1:0] al_minutes,
  output logic [HR_W-1:0]  al_hours,
  output logic             al_on,
  output logic             alarm
);

  localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

  logic [NUM_REQ-1:0] pulse, req, grant, pend_q, pend_d;
  logic [SEC_W-1:0]   sec_q, sec_d, min_q, min_d, alm_q, alm_d;
  logic [HR_W-1:0]    hrs_q, hrs_d, alh_q, alh_d;
  logic [SEC_W-1:0]   sec_next, min_next, alm_next;
  logic [HR_W-1:0]    hrs_next, alh_next;
  logic               sec_carry, min_carry, alm_carry;
  logic               unused_hrs_carry, unused_alh_carry;
  al_state_e          state_q;
  logic [7:0]         ring_q;
  logic               al_on_q, alarm_q;
  logic               match;

  assign pulse[REQ_TICK] = tick_1hz;
  assign pulse[REQ_SEC]  = sec_adj;
  assign pulse[REQ_MIN]  = min_adj;
  assign pulse[REQ_HRS]  = hrs_adj;
  assign pulse[REQ_AL]   = al_adj;

  // A losing request parks in its pending flag; a repeat pulse merges into it
  assign req    = pulse | pend_q;
  assign grant  = first_set(req);
  assign pend_d = req & ~grant;

  wrap_inc #(.W(SEC_W), .MAX(MIN_SEC_MAX), .STEP(1)) u_sec (
    .val_i(sec_q), .next_o(sec_next), .carry_o(sec_carry));
  wrap_inc #(.W(SEC_W), .MAX(MIN_SEC_MAX), .STEP(1)) u_min (
    .val_i(min_q), .next_o(min_next), .carry_o(min_carry));
  wrap_inc #(.W(HR_W), .MAX(HOURS_MOD - 1), .STEP(1)) u_hrs (
    .val_i(hrs_q), .next_o(hrs_next), .carry_o(unused_hrs_carry));
  wrap_inc #(.W(SEC_W), .MAX(MIN_SEC_MAX), .STEP(AL_STEP)) u_alm (
    .val_i(alm_q), .next_o(alm_next), .carry_o(alm_carry));
  wrap_inc #(.W(HR_W), .MAX(HOURS_MOD - 1), .STEP(1)) u_alh (
    .val_i(alh_q), .next_o(alh_next), .carry_o(unused_alh_carry));

  // Only the tick and alarm-adjust grants propagate carries into the next field
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hrs_d = hrs_q;
    alm_d = alm_q;
    alh_d = alh_q;
    if (grant[REQ_TICK]) begin
      sec_d = sec_next;
      if (sec_carry) begin
        min_d = min_next;
        if (min_carry) hrs_d = hrs_next;
      end
    end
    if (grant[REQ_SEC]) sec_d = sec_next;
    if (grant[REQ_MIN]) min_d = min_next;
    if (grant[REQ_HRS]) hrs_d = hrs_next;
    if (grant[REQ_AL]) begin
      alm_d = alm_next;
      if (alm_carry) alh_d = alh_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hrs_q  <= '0;
      alm_q  <= '0;
      alh_q  <= '0;
    end else begin
      pend_q <= pend_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hrs_q  <= hrs_d;
      alm_q  <= alm_d;
      alh_q  <= alh_d;
    end
  end

  assign match = (hrs_q == alh_q) && (min_q == alm_q);

  // Toggle is checked first in every state so it always beats a match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      ring_q  <= '0;
      al_on_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          if (al_toggle) begin
            state_q <= ARMED;
            al_on_q <= 1'b1;
          end
        end
        ARMED: begin
          if (al_toggle) begin
            state_q <= OFF;
            al_on_q <= 1'b0;
          end else if (match) begin
            state_q <= RINGING;
            ring_q  <= RING_LOAD;
            alarm_q <= 1'b1;
          end
        end
        RINGING: begin
          if (al_toggle) begin
            state_q <= OFF;
            ring_q  <= '0;
            al_on_q <= 1'b0;
            alarm_q <= 1'b0;
          end else if (tick_1hz) begin
            ring_q <= ring_q - 8'd1;
            if (ring_q == 8'd1) begin
              state_q <= HOLDOFF;
              alarm_q <= 1'b0;
            end
          end
        end
        HOLDOFF: begin
          if (al_toggle) begin
            state_q <= OFF;
            al_on_q <= 1'b0;
          end else if (!match) begin
            state_q <= ARMED;
          end
        end
        default: begin
          state_q <= OFF;
          ring_q  <= '0;
          al_on_q <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign hours      = hrs_q;
  assign al_minutes = alm_q;
  assign al_hours   = alh_q;
  assign al_on      = al_on_q;
  assign alarm      = alarm_q;

endmodule

// File: doc/time_alarm_ctrl.md
# time_alarm_ctrl

Sequencer for the clock's timekeeping and alarm registers. Arbitrates between the 1 Hz tick and the debounced button pulses, so at most one register update is applied per cycle. Runs an alarm state machine that drives `al_on` and `alarm`. Sits between the `clock_div`/`button_debounce` instances and the `clockRenderer`/buzzer logic in `classic_vga_clock`, replacing the ad-hoc update logic in the top level.

## Interface
Parameters:
- `RING_SECS`, 60: seconds the alarm rings before self-silencing; range 1..255.
- `HOURS_MOD`, 12: hour field modulus.

Ports:
- `clk`  in  1  system clock, 31.5 MHz.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `tick_1hz`  in  1  one-cycle pulse, 1 Hz.
- `sec_adj`, `min_adj`, `hrs_adj`, `al_adj`  in  1 each  one-cycle debounced adjust pulses.
- `al_toggle`  in  1  one-cycle alarm on/off pulse.
- `seconds`, `minutes`  out  6 each  current time, 0..59.
- `hours`  out  4  current hour, 0..HOURS_MOD-1.
- `al_minutes`  out  6  alarm minute, multiple of 10 after any `al_adj`, 0..59.
- `al_hours`  out  4  alarm hour.
- `al_on`  out  1  alarm armed; high in every state except OFF.
- `alarm`  out  1  ringing; high only in RINGING.

## Operation
- Requests: tick, sec, min, hrs, al. Effective request = input pulse OR pending flag.
- Fixed priority, one grant per cycle: tick > sec > min > hrs > al.
- A request that is not granted sets its pending flag. The flag clears on grant. A second pulse while pending merges and is lost by design.
- Tick grant: seconds+1. On wrap 59→0, minutes+1. On minutes wrap 59→0, hours+1 mod HOURS_MOD. Full carry happens in the same cycle.
- sec/min/hrs grants: field+1 with field-local wrap, no carry.
- al grant: al_minutes+10. On reaching ≥60 it wraps to 0 and al_hours+1 mod HOURS_MOD.
- Out-of-range values are unreachable; arithmetic uses compare-to-max, not ≥.
- Alarm FSM states: OFF, ARMED, RINGING, HOLDOFF.
  - OFF→ARMED on `al_toggle`.
  - `al_toggle` in ARMED, RINGING or HOLDOFF →OFF.
  - ARMED→RINGING when registered hours==al_hours and minutes==al_minutes. Ring counter loads RING_SECS.
  - RINGING: counter decrements on each `tick_1hz`. When it reaches 0 →HOLDOFF.
  - HOLDOFF→ARMED once the time no longer matches the alarm time. This prevents re-trigger in the same minute.
- `al_toggle` has no arbitration and is always acted on in its cycle. Toggle beats match in the same cycle.
- Alarm adjust while RINGING changes al_* registers but does not stop ringing.

## Timing
- Reset (async assert): all time/alarm fields 0, pending flags 0, state OFF, ring counter 0, `al_on`=0, `alarm`=0.
- Reset deassertion is synchronous to `clk` at the integrating level.
- Uncontended pulse in cycle N: field updated and visible in cycle N+1.
- Contended pulse: visible one cycle after the cycle it is granted. Worst case with tick plus all four adjusts is N+5.
- A match visible in cycle N gives `alarm`=1 in N+1.
- `al_toggle` in cycle N: `al_on`/`alarm` change in N+1.
- After entering RINGING, `alarm` falls after exactly RING_SECS tick pulses. It is high through the cycle of the final tick's edge.
- Reset mid-ring drops `alarm` immediately (asynchronous).

## Structure
- Shared package `clock_pkg` holds:
  - Field widths: SEC_W=6, HR_W=4.
  - Constants MIN_SEC_MAX=59 and AL_STEP=10.
  - The alarm state enum (OFF, ARMED, RINGING, HOLDOFF).
  - The request-index constants.
- One sub-module, `wrap_inc`: parameterised width/max/step, returns next value and carry. It is instantiated for seconds, minutes, hours, al_minutes and al_hours.
- Priority grant and FSM stay in the top of this block.

## Test plan
- Reset, then 59 tick pulses with time 00:00:00 → seconds=59. Next tick → 00:01:00 one cycle later.
- Preload 11:59:59, then tick → 00:00:00. Separately, from 00:59:00 a `min_adj` → minutes=0, hours still 0.
- `tick_1hz` and `sec_adj` in the same cycle from seconds=5 → seconds=6 at N+1 and 7 at N+2. Pending sec flag seen high in N+1 only.
- 7× `al_adj` from 0 → al_minutes 10,20,30,40,50,0 (al_hours=1), then 10.
- Set al 00:10, toggle on, advance time to 00:10:00 → `alarm`=1 next cycle. After 60 ticks `alarm`=0 and state is HOLDOFF. At 00:11:00 state is ARMED with no re-ring.
- While RINGING, `al_toggle` → `al_on`=0 and `alarm`=0 next cycle. Reset asserted mid-ring → outputs 0 without a clock edge.
